// File: rtl/clk_enable_gen.sv
// rtl/clk_enable_gen.sv - single-clock tick enable generator with run/fast/halt/step modes
module clk_enable_gen #(
    parameter int CNT_WIDTH       = 24,
    parameter int COUNT_WIDTH     = 32,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             mode,
    input  logic [CNT_WIDTH-1:0]   tick_div,
    input  logic                   step_btn,
    output logic                   tick,
    output logic                   slow_clk,
    output logic [COUNT_WIDTH-1:0] tick_count,
    output logic                   btn_level
);

    localparam logic [1:0] MODE_HALT = 2'b00;
    localparam logic [1:0] MODE_RUN  = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;
    localparam logic [1:0] MODE_FAST = 2'b11;

    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // Button synchroniser, debouncer and edge-detect state
    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            btn_level_q, btn_level_d;
    logic            btn_dly_q, btn_dly_d;

    // Rate counter and tick outputs
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   tick_q, tick_d;
    logic                   slow_clk_q, slow_clk_d;
    logic [COUNT_WIDTH-1:0] tick_count_q, tick_count_d;

    logic btn_rise;

    // Synchroniser and debounce: the level only follows sync2 after it has
    // differed for DEBOUNCE_CYCLES consecutive cycles
    always_comb begin
        sync1_d     = step_btn;
        sync2_d     = sync1_q;
        db_cnt_d    = db_cnt_q;
        btn_level_d = btn_level_q;
        if (sync2_q == btn_level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            btn_level_d = sync2_q;
            db_cnt_d    = '0;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
        btn_dly_d = btn_level_q;
    end

    assign btn_rise = btn_level_q & ~btn_dly_q;

    // Tick decision per mode; the rate counter only runs in RUN so entering
    // RUN always starts a fresh period
    always_comb begin
        cnt_d  = '0;
        tick_d = 1'b0;
        unique case (mode)
            MODE_RUN: begin
                if (cnt_q >= tick_div) begin
                    tick_d = 1'b1;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            MODE_FAST: tick_d = 1'b1;
            MODE_STEP: tick_d = btn_rise;
            MODE_HALT: tick_d = 1'b0;
            default:   tick_d = 1'b0;
        endcase
    end

    // LED square wave and debug counter advance on every issued tick
    always_comb begin
        slow_clk_d   = slow_clk_q;
        tick_count_d = tick_count_q;
        if (tick_d) begin
            slow_clk_d   = ~slow_clk_q;
            tick_count_d = tick_count_q + 1'b1;
        end
    end

    // State registers, reset dominates everything
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            db_cnt_q     <= '0;
            btn_level_q  <= 1'b0;
            btn_dly_q    <= 1'b0;
            cnt_q        <= '0;
            tick_q       <= 1'b0;
            slow_clk_q   <= 1'b0;
            tick_count_q <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            db_cnt_q     <= db_cnt_d;
            btn_level_q  <= btn_level_d;
            btn_dly_q    <= btn_dly_d;
            cnt_q        <= cnt_d;
            tick_q       <= tick_d;
            slow_clk_q   <= slow_clk_d;
            tick_count_q <= tick_count_d;
        end
    end

    assign tick       = tick_q;
    assign slow_clk   = slow_clk_q;
    assign tick_count = tick_count_q;
    assign btn_level  = btn_level_q;

endmodule

// File: tb/tb_clk_enable_gen.sv
// tb/tb_clk_enable_gen.sv - directed self-checking bench for clk_enable_gen
module tb_clk_enable_gen;

    localparam int CW = 8;
    localparam int KW = 4;
    localparam int DB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    mode = 2'b00;
    logic [CW-1:0] tick_div = '0;
    logic          step_btn = 1'b0;
    logic          tick;
    logic          slow_clk;
    logic [KW-1:0] tick_count;
    logic          btn_level;

    int total = 0;
    int bad   = 0;

    clk_enable_gen #(
        .CNT_WIDTH(CW),
        .COUNT_WIDTH(KW),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mode(mode),
        .tick_div(tick_div),
        .step_btn(step_btn),
        .tick(tick),
        .slow_clk(slow_clk),
        .tick_count(tick_count),
        .btn_level(btn_level)
    );

    always #5 clk = ~clk;

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut(input logic [1:0] m);
        mode     = m;
        step_btn = 1'b0;
        rst      = 1'b1;
        repeat (3) clk1();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        mode = 2'b11;
        rst  = 1'b1;
        repeat (3) clk1();
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick got %0b want 0", tick); end
        total++; if (slow_clk !== 1'b0) begin bad++; $display("FAIL reset_slow got %0b want 0", slow_clk); end
        total++; if (tick_count !== 4'h0) begin bad++; $display("FAIL reset_count got %0h want 0", tick_count); end
        total++; if (btn_level !== 1'b0) begin bad++; $display("FAIL reset_btn got %0b want 0", btn_level); end
        rst = 1'b0;
        clk1();
        total++; if (tick !== 1'b1) begin bad++; $display("FAIL fast_first_tick got %0b want 1", tick); end
        total++; if (tick_count !== 4'h1) begin bad++; $display("FAIL fast_first_count got %0h want 1", tick_count); end
        total++; if (slow_clk !== 1'b1) begin bad++; $display("FAIL fast_first_slow got %0b want 1", slow_clk); end
    endtask

    task automatic test_run();
        reset_dut(2'b00);
        mode     = 2'b01;
        tick_div = 8'd3;
        for (int e = 1; e <= 20; e++) begin
            clk1();
            total++;
            if (tick !== ((e % 4) == 0)) begin
                bad++; $display("FAIL run_tick edge %0d got %0b want %0b", e, tick, ((e % 4) == 0));
            end
            total++;
            if (slow_clk !== ((e / 4) % 2 == 1)) begin
                bad++; $display("FAIL run_slow edge %0d got %0b want %0b", e, slow_clk, ((e / 4) % 2 == 1));
            end
        end
        total++; if (tick_count !== 4'd5) begin bad++; $display("FAIL run_count got %0d want 5", tick_count); end
        tick_div = 8'd0;
        for (int e = 1; e <= 5; e++) begin
            clk1();
            total++; if (tick !== 1'b1) begin bad++; $display("FAIL div0_tick edge %0d got %0b want 1", e, tick); end
        end
        total++; if (tick_count !== 4'd10) begin bad++; $display("FAIL div0_count got %0d want 10", tick_count); end
    endtask

    task automatic test_rate_change();
        logic exp;
        reset_dut(2'b00);
        mode     = 2'b01;
        tick_div = 8'd100;
        for (int e = 1; e <= 10; e++) begin
            clk1();
            total++; if (tick !== 1'b0) begin bad++; $display("FAIL rate_pre edge %0d got %0b want 0", e, tick); end
        end
        tick_div = 8'd5;
        for (int e = 11; e <= 23; e++) begin
            clk1();
            exp = (e == 11) || (e == 17) || (e == 23);
            total++; if (tick !== exp) begin bad++; $display("FAIL rate_post edge %0d got %0b want %0b", e, tick, exp); end
        end
        total++; if (tick_count !== 4'd3) begin bad++; $display("FAIL rate_count got %0d want 3", tick_count); end
    endtask

    task automatic test_step();
        reset_dut(2'b10);
        step_btn = 1'b1;
        repeat (3) clk1();
        step_btn = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            clk1();
            total++; if (tick !== 1'b0) begin bad++; $display("FAIL glitch_tick edge %0d got %0b want 0", e, tick); end
            total++; if (btn_level !== 1'b0) begin bad++; $display("FAIL glitch_btn edge %0d got %0b want 0", e, btn_level); end
        end
        for (int p = 1; p <= 2; p++) begin
            step_btn = 1'b1;
            for (int e = 1; e <= 10; e++) begin
                clk1();
                total++; if (btn_level !== (e >= 6)) begin bad++; $display("FAIL press%0d_btn edge %0d got %0b want %0b", p, e, btn_level, (e >= 6)); end
                total++; if (tick !== (e == 7)) begin bad++; $display("FAIL press%0d_tick edge %0d got %0b want %0b", p, e, tick, (e == 7)); end
            end
            step_btn = 1'b0;
            for (int e = 1; e <= 10; e++) begin
                clk1();
                total++; if (tick !== 1'b0) begin bad++; $display("FAIL release%0d_tick edge %0d got %0b want 0", p, e, tick); end
            end
            total++; if (btn_level !== 1'b0) begin bad++; $display("FAIL release%0d_btn got %0b want 0", p, btn_level); end
        end
        total++; if (tick_count !== 4'd2) begin bad++; $display("FAIL step_count got %0d want 2", tick_count); end
    endtask

    task automatic test_halt();
        reset_dut(2'b00);
        mode     = 2'b01;
        tick_div = 8'd3;
        repeat (8) clk1();
        total++; if (tick_count !== 4'd2) begin bad++; $display("FAIL halt_pre_count got %0d want 2", tick_count); end
        mode = 2'b00;
        for (int e = 1; e <= 6; e++) begin
            clk1();
            total++; if (tick !== 1'b0) begin bad++; $display("FAIL halt_tick edge %0d got %0b want 0", e, tick); end
            total++; if (tick_count !== 4'd2) begin bad++; $display("FAIL halt_count edge %0d got %0d want 2", e, tick_count); end
            total++; if (slow_clk !== 1'b0) begin bad++; $display("FAIL halt_slow edge %0d got %0b want 0", e, slow_clk); end
        end
        mode = 2'b01;
        for (int e = 1; e <= 4; e++) begin
            clk1();
            total++; if (tick !== (e == 4)) begin bad++; $display("FAIL resume_tick edge %0d got %0b want %0b", e, tick, (e == 4)); end
        end
        total++; if (slow_clk !== 1'b1) begin bad++; $display("FAIL resume_slow got %0b want 1", slow_clk); end
        mode     = 2'b00;
        step_btn = 1'b1;
        repeat (10) clk1();
        total++; if (btn_level !== 1'b1) begin bad++; $display("FAIL halt_press_btn got %0b want 1", btn_level); end
        mode = 2'b10;
        for (int e = 1; e <= 5; e++) begin
            clk1();
            total++; if (tick !== 1'b0) begin bad++; $display("FAIL discard_tick edge %0d got %0b want 0", e, tick); end
        end
        total++; if (tick_count !== 4'd3) begin bad++; $display("FAIL discard_count got %0d want 3", tick_count); end
        step_btn = 1'b0;
    endtask

    task automatic test_wrap();
        reset_dut(2'b11);
        step_btn = 1'b1;
        for (int e = 1; e <= 17; e++) begin
            clk1();
            total++; if (tick_count !== 4'(e)) begin bad++; $display("FAIL wrap_count edge %0d got %0h want %0h", e, tick_count, 4'(e)); end
        end
        total++; if (btn_level !== 1'b1) begin bad++; $display("FAIL wrap_btn got %0b want 1", btn_level); end
        rst = 1'b1;
        clk1();
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL midrst_tick got %0b want 0", tick); end
        total++; if (slow_clk !== 1'b0) begin bad++; $display("FAIL midrst_slow got %0b want 0", slow_clk); end
        total++; if (tick_count !== 4'h0) begin bad++; $display("FAIL midrst_count got %0h want 0", tick_count); end
        total++; if (btn_level !== 1'b0) begin bad++; $display("FAIL midrst_btn got %0b want 0", btn_level); end
        rst      = 1'b0;
        step_btn = 1'b0;
    endtask

    initial begin
        test_reset();
        test_run();
        test_rate_change();
        test_step();
        test_halt();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_enable_gen.md
Name: clk_enable_gen

Overview:
Parametrised clock-enable generator for the RV32I board top. It replaces the derived "counter bit as clock" scheme with a single-cycle enable pulse (tick) that the core qualifies its state updates with, so the whole design stays on one clock. It supports free-run at a programmable rate, full speed, halt, and debounced single-step from a push button. It also provides a square-wave view of the rate for LEDs and a tick counter for debug.

Parameters:
CNT_WIDTH, 24, width of the rate counter and of tick_div
COUNT_WIDTH, 32, width of tick_count
DEBOUNCE_CYCLES, 1000000, number of consecutive cycles the synchronised button must differ from the debounced level before the level changes (>= 2)

Ports:
clk  input  1  system clock, single clock domain
rst  input  1  synchronous, active-high reset
mode  input  2  00 HALT, 01 RUN, 10 STEP, 11 FAST; synchronous to clk, no internal synchroniser
tick_div  input  CNT_WIDTH  in RUN, tick period is tick_div+1 cycles; synchronous to clk
step_btn  input  1  raw asynchronous push button
tick  output  1  one-cycle clock-enable pulse, registered
slow_clk  output  1  toggles on every tick, registered
tick_count  output  COUNT_WIDTH  ticks issued since reset, wraps
btn_level  output  1  debounced button level

Behaviour:
- Reset (rst=1 at a clk edge): tick=0, slow_clk=0, tick_count=0, btn_level=0, rate counter=0, sync flops=0, debounce counter=0, edge-detect delay flop=0.
- rst dominates all other inputs. Reset mid-run clears state at that edge, and any pending tick is lost.
- Rate counter (cnt, CNT_WIDTH bits):
  - Cleared on every edge where mode != RUN.
- RUN, at each edge:
  - If cnt >= tick_div: tick<=1 and cnt<=0.
  - Otherwise: tick<=0 and cnt<=cnt+1.
  - The first tick after entering RUN is on the (tick_div+1)th RUN edge. The steady period is tick_div+1 cycles.
  - tick_div=0 gives a tick on every edge.
  - If tick_div is lowered to or below the current cnt, the tick occurs at the next edge (>= compare). There is no wrap or stall.
- FAST: tick<=1 on every edge.
- HALT: tick<=0. slow_clk and tick_count hold.
- STEP: tick<=1 for exactly one edge per rising edge of btn_level; otherwise tick<=0.
  - A btn_level rise while not in STEP is discarded, not queued.
- Button path:
  - Two-flop synchroniser: sync1 feeds sync2.
  - Debounce counter, at each edge:
    - If sync2 == btn_level: counter<=0.
    - Else if counter == DEBOUNCE_CYCLES-1: btn_level<=sync2 and counter<=0.
    - Else: counter<=counter+1.
  - Pulses shorter than DEBOUNCE_CYCLES synchronised cycles never change btn_level.
  - Edge detect: a delay flop holds the previous btn_level. rise = btn_level & ~delay. tick (STEP) is registered from rise.
  - Latency: with step_btn held high, first sampled at edge 1:
    - btn_level rises at edge DEBOUNCE_CYCLES+2.
    - tick is high after edge DEBOUNCE_CYCLES+3 for one cycle.
  - Release is debounced identically and produces no tick.
- On every edge that sets tick<=1:
  - slow_clk<=~slow_clk.
  - tick_count<=tick_count+1, wrapping from all-ones to 0.
- Mode changes take effect at the next edge. There is no partial-period carry-over into or out of RUN.

Test Plan:
- Reset: rst=1 for 3 edges during FAST mode -> tick=0, slow_clk=0, tick_count=0, btn_level=0. After release, FAST gives tick=1 from the first edge.
- RUN, tick_div=3, 20 edges from entry -> tick at edges 4,8,12,16,20, tick_count=5, slow_clk period 8 cycles. tick_div=0 -> tick every edge.
- Rate change: RUN, tick_div=100, at cnt=10 set tick_div=5 -> tick at the next edge, then every 6 cycles.
- STEP, DEBOUNCE_CYCLES=4: 3-cycle glitch on step_btn -> no tick, btn_level stays 0. Hold 10 cycles -> btn_level=1 at edge 6, single tick at edge 7. Release 10 cycles, press again -> second tick, tick_count=2.
- HALT mid-run after 2 ticks: no ticks, slow_clk and tick_count hold. Return to RUN with tick_div=3 -> next tick on the 4th RUN edge. Press in HALT then switch to STEP -> no tick.
- Wrap: COUNT_WIDTH=4, FAST for 17 edges -> tick_count reads 0xF then 0x0, then 0x1. Assert rst mid-count -> all outputs 0 at the next edge.
